free_list_mp: RTL and testbench
===============================

FREE_LIST_MP -- requirements
Module: free_list_mp

Interface
REQ-001 SHALL have parameter PRF_DEPTH, default 64, number of physical registers (power of two).
REQ-002 SHALL have parameter ARF_NUM, default 32, architectural registers mapped at reset; FL_DEPTH = PRF_DEPTH - ARF_NUM, power of two.
REQ-003 SHALL have parameter DQ_WIDTH, default 2, allocation lanes.
REQ-004 SHALL have parameter EQ_WIDTH, default 2, release lanes.
REQ-005 SHALL have ports, in order:
- clk  in  1  clock; one clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alloc_valid  in  DQ_WIDTH x 1  per-lane allocation request.
- alloc_ready  out  1  free list can grant all DQ_WIDTH lanes.
- free_idx  out  DQ_WIDTH x $clog2(PRF_DEPTH)  granted physical index per lane.
- release_valid  in  EQ_WIDTH x 1  per-lane stale register return (from RRF).
- stale_idx  in  EQ_WIDTH x $clog2(PRF_DEPTH)  returned index per lane.
- flush  in  1  mispredict recovery; reclaim all speculative allocations.
- free_count  out  $clog2(FL_DEPTH+1)  current number of free entries.
- err  out  1  sticky protocol error (see Configuration).

Function
REQ-006 SHALL store indices in a FL_DEPTH-entry circular buffer with rd_ptr/wr_ptr of $clog2(FL_DEPTH)+1 bits (MSB = wrap bit); free_count = wr_ptr - rd_ptr.
REQ-007 alloc_ready SHALL be combinational: 1 iff free_count >= DQ_WIDTH.
REQ-008 free_idx[i] SHALL equal mem[rd_ptr + popcount(alloc_valid[0..i-1])] (lane compaction); valid for lanes with alloc_valid[i]=1, don't-care otherwise.
REQ-009 On a rising edge with alloc_ready=1 and flush=0, rd_ptr SHALL advance by popcount(alloc_valid); with alloc_ready=0 alloc_valid SHALL be ignored, no state change.
REQ-010 Releases SHALL be compacted in lane order: lane i writes stale_idx[i] to mem[wr_ptr + popcount(release_valid[0..i-1])]; wr_ptr advances by popcount(release_valid).
REQ-011 Simultaneous alloc and release in one cycle SHALL both take effect; alloc_ready uses pre-release count (no same-cycle bypass).
REQ-012 On flush=1: releases of that cycle SHALL apply first, then rd_ptr := new wr_ptr with MSB inverted (free_count = FL_DEPTH); allocations that cycle SHALL be ignored.
REQ-013 Dequeue SHALL not erase entries; region [wr_ptr, rd_ptr) retains in-flight indices in allocation order, which makes REQ-012 exact under in-order commit.
REQ-014 Pointer arithmetic SHALL wrap modulo 2*FL_DEPTH; index wrap modulo FL_DEPTH.
REQ-015 A release when free_count + popcount(release_valid) > FL_DEPTH is illegal; excess lanes SHALL be dropped (no wr_ptr advance past full).

Reset
REQ-016 On rst_n=0 (async) mem[k] SHALL become ARF_NUM + k for k in 0..FL_DEPTH-1, rd_ptr=0, wr_ptr=FL_DEPTH (wrap bit set), err=0.
REQ-017 Reset values: free_count=FL_DEPTH, alloc_ready=1 (FL_DEPTH>=DQ_WIDTH), free_idx[i]=ARF_NUM+i with all alloc_valid high.
REQ-018 Reset asserted mid-operation SHALL override flush, alloc and release of that cycle.

Configuration
REQ-019 Macro FREE_LIST_CHECK_EN: when defined, an illegal release (REQ-015) or alloc_valid when alloc_ready=0 SHALL set err=1 at next edge, held until reset; when undefined, err SHALL be tied 0 and no checking logic synthesised; dropping per REQ-015 is unchanged.

Verification (PRF_DEPTH=64, ARF_NUM=32, DQ=EQ=2)
REQ-020 Release rst_n -> free_count=32, alloc_ready=1, free_idx={32,33}.
REQ-021 alloc_valid={0,1} one cycle -> free_idx[1]=32; next cycle free_idx[0]=33, free_count=31.
REQ-022 16 dual allocs -> free_count=0, alloc_ready=0; further alloc_valid={1,1} leaves count 0, err=1 only with FREE_LIST_CHECK_EN.
REQ-023 From free_count=2: dual alloc + dual release {0,1} same cycle -> free_count=2; later allocs return 0,1 after wrap.
REQ-024 After reset alloc 5 (32..36), release {0,1}, then flush -> free_count=32; next allocs 34,35,...,63,0,1.
REQ-025 At free_count=32, release_valid={1,0} stale_idx=5 -> free_count stays 32, entry dropped, err=1 iff FREE_LIST_CHECK_EN.

Source files
------------

// File: rtl/free_list_mp.sv
// -----------------------------------------------------------------------------
// free_list_mp
//
// Multi-port free list of physical register indices for a register renamer.
// The list is a FL_DEPTH-entry circular buffer of indices. At reset it holds
// ARF_NUM .. PRF_DEPTH-1, the physical registers not used by the initial
// architectural mapping.
//
// Allocation pops up to DQ_WIDTH indices per cycle. Release pushes up to
// EQ_WIDTH stale indices per cycle. Both sides compact lanes in lane order.
//
// Dequeue never erases entries. The region [wr_ptr, rd_ptr) therefore still
// holds every in-flight index in allocation order. A flush can reclaim all
// speculative allocations by moving rd_ptr back to one full buffer behind
// wr_ptr.
//
// Optional feature (macro FREE_LIST_CHECK_EN):
//   When defined, err becomes a sticky flag. It is set by an over-full release
//   or by alloc_valid while alloc_ready=0, and is held until reset.
//   When undefined, err is tied low and no checking logic exists.
//
// Parameters
//   PRF_DEPTH   number of physical registers (power of two)
//   ARF_NUM     architectural registers mapped at reset;
//               PRF_DEPTH-ARF_NUM must be a power of two, >= 2
//   DQ_WIDTH    allocation lanes
//   EQ_WIDTH    release lanes
//
// Ports
//   clk            clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   alloc_valid    per-lane allocation request
//   alloc_ready    high when all DQ_WIDTH lanes can be granted this cycle
//   free_idx       granted index per lane (meaningful where alloc_valid=1)
//   release_valid  per-lane stale register return
//   stale_idx      returned index per lane
//   flush          mispredict recovery, reclaims all speculative allocations
//   free_count     number of free entries
//   err            sticky protocol error (0 unless FREE_LIST_CHECK_EN)
// -----------------------------------------------------------------------------
module free_list_mp #(
    parameter int PRF_DEPTH = 64,
    parameter int ARF_NUM   = 32,
    parameter int DQ_WIDTH  = 2,
    parameter int EQ_WIDTH  = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [DQ_WIDTH-1:0]                          alloc_valid,
    output logic                                         alloc_ready,
    output logic [DQ_WIDTH-1:0][$clog2(PRF_DEPTH)-1:0]   free_idx,
    input  logic [EQ_WIDTH-1:0]                          release_valid,
    input  logic [EQ_WIDTH-1:0][$clog2(PRF_DEPTH)-1:0]   stale_idx,
    input  logic                                         flush,
    output logic [$clog2(PRF_DEPTH-ARF_NUM+1)-1:0]       free_count,
    output logic                                         err
);

    localparam int FL_DEPTH = PRF_DEPTH - ARF_NUM;
    localparam int IDX_W    = $clog2(PRF_DEPTH);
    localparam int AW       = $clog2(FL_DEPTH);
    localparam int PTR_W    = AW + 1;
    localparam int CNT_W    = $clog2(FL_DEPTH + 1);

    logic [IDX_W-1:0] mem_q [FL_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [PTR_W-1:0] cnt;
    logic [PTR_W-1:0] rd_ofs;
    logic [PTR_W-1:0] wr_ofs;
    logic [AW-1:0]    rd_addr [DQ_WIDTH];
    logic [AW-1:0]    wr_addr [EQ_WIDTH];
    logic [EQ_WIDTH-1:0] rel_acc;

    // Occupancy and read-side lane compaction.
    always_comb begin
        cnt         = wr_ptr_q - rd_ptr_q;
        alloc_ready = (cnt >= PTR_W'(DQ_WIDTH));
        rd_ofs      = '0;
        for (int i = 0; i < DQ_WIDTH; i++) begin
            rd_addr[i]  = rd_ptr_q[AW-1:0] + rd_ofs[AW-1:0];
            free_idx[i] = mem_q[rd_addr[i]];
            rd_ofs      = rd_ofs + PTR_W'(alloc_valid[i]);
        end
    end

    assign free_count = CNT_W'(cnt);

    // Write-side lane compaction. A lane is accepted only while the buffer,
    // counted with the lanes already accepted this cycle, is still below full.
    // Any excess lanes are dropped, so wr_ptr never overtakes free entries.
    always_comb begin
        wr_ofs  = '0;
        rel_acc = '0;
        for (int i = 0; i < EQ_WIDTH; i++) begin
            wr_addr[i] = wr_ptr_q[AW-1:0] + wr_ofs[AW-1:0];
            rel_acc[i] = release_valid[i] && ((cnt + wr_ofs) < PTR_W'(FL_DEPTH));
            if (rel_acc[i]) begin
                wr_ofs = wr_ofs + PTR_W'(1);
            end
        end
    end

    // Pointer next-state. On a flush, rd_ptr lands exactly FL_DEPTH behind the
    // post-release wr_ptr: same index, opposite wrap bit.
    always_comb begin
        wr_ptr_d = wr_ptr_q + wr_ofs;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = {~wr_ptr_d[PTR_W-1], wr_ptr_d[PTR_W-2:0]};
        end else if (alloc_ready) begin
            rd_ptr_d = rd_ptr_q + rd_ofs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= PTR_W'(FL_DEPTH);
            for (int k = 0; k < FL_DEPTH; k++) begin
                mem_q[k] <= IDX_W'(ARF_NUM + k);
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            for (int i = 0; i < EQ_WIDTH; i++) begin
                if (rel_acc[i]) begin
                    mem_q[wr_addr[i]] <= stale_idx[i];
                end
            end
        end
    end

`ifdef FREE_LIST_CHECK_EN
    localparam int SUM_W = PTR_W + $clog2(EQ_WIDTH + 1);

    logic [SUM_W-1:0] rel_sum;
    logic             rel_illegal;
    logic             alloc_illegal;
    logic             err_q, err_d;

    // The illegal-release test uses every requested lane, including lanes
    // that the write side drops.
    always_comb begin
        rel_sum = SUM_W'(cnt);
        for (int i = 0; i < EQ_WIDTH; i++) begin
            rel_sum = rel_sum + SUM_W'(release_valid[i]);
        end
        rel_illegal   = (rel_sum > SUM_W'(FL_DEPTH));
        alloc_illegal = (|alloc_valid) && !alloc_ready;
        err_d         = err_q | rel_illegal | alloc_illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_mp.sv
module tb_free_list_mp;

    localparam int PRF = 64;
    localparam int ARF = 32;
    localparam int FL  = PRF - ARF;
    localparam int DQ  = 2;
    localparam int EQ  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [DQ-1:0]        alloc_valid;
    logic                 alloc_ready;
    logic [DQ-1:0][5:0]   free_idx;
    logic [EQ-1:0]        release_valid;
    logic [EQ-1:0][5:0]   stale_idx;
    logic                 flush;
    logic [5:0]           free_count;
    logic                 err;

    free_list_mp #(.PRF_DEPTH(PRF), .ARF_NUM(ARF), .DQ_WIDTH(DQ), .EQ_WIDTH(EQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .free_idx     (free_idx),
        .release_valid(release_valid),
        .stale_idx    (stale_idx),
        .flush        (flush),
        .free_count   (free_count),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int rdy;
        int errv;
        int idx0;   // -1: lane not checked
        int idx1;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: hist logs every index ever placed in the list, in order.
    // The free entries are hist[taken .. end]. A flush reclaims the last FL
    // logged entries.
    int hist[$];
    int taken;
    int err_m;

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < FL; k++) hist.push_back(ARF + k);
        taken = 0;
        err_m = 0;
    endtask

    task automatic check(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    endtask

    // Monitor: one expectation per active cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("free_count", int'(free_count), e.cnt);
                check("alloc_ready", int'(alloc_ready), e.rdy);
                check("err", int'(err), e.errv);
                if (e.idx0 >= 0) check("free_idx0", int'(free_idx[0]), e.idx0);
                if (e.idx1 >= 0) check("free_idx1", int'(free_idx[1]), e.idx1);
            end
        end
    end

    task automatic step(input logic [1:0] av, input logic [1:0] rv,
                        input int s0, input int s1, input bit fl);
        exp_t e;
        int cnt, pos, acc, nrel;
        bit rdy;
        @(posedge clk); #1;
        alloc_valid   = av;
        release_valid = rv;
        stale_idx[0]  = 6'(s0);
        stale_idx[1]  = 6'(s1);
        flush         = fl;

        cnt    = hist.size() - taken;
        rdy    = (cnt >= DQ);
        e.cnt  = cnt;
        e.rdy  = int'(rdy);
        e.errv = err_m;
        pos    = taken;
        e.idx0 = (av[0] && rdy) ? hist[pos] : -1;
        if (av[0]) pos++;
        e.idx1 = (av[1] && rdy) ? hist[pos] : -1;
        sb_q.push_back(e);

        nrel = int'(rv[0]) + int'(rv[1]);
        acc  = 0;
        if (rv[0] && (cnt + acc < FL)) begin hist.push_back(s0); acc++; end
        if (rv[1] && (cnt + acc < FL)) begin hist.push_back(s1); acc++; end
        if (fl) taken = hist.size() - FL;
        else if (rdy) taken = taken + int'(av[0]) + int'(av[1]);
`ifdef FREE_LIST_CHECK_EN
        if ((cnt + nrel > FL) || (av != 2'b00 && !rdy)) err_m = 1;
`else
        if (nrel < 0) err_m = 1;
`endif
    endtask

    task automatic do_reset(input bit busy);
        @(posedge clk); #1;
        if (busy) begin
            alloc_valid   = 2'($urandom_range(1, 3));
            release_valid = 2'b11;
            stale_idx[0]  = 6'($urandom_range(0, 63));
            stale_idx[1]  = 6'($urandom_range(0, 63));
            flush         = 1'b1;
        end
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        alloc_valid   = '0;
        release_valid = '0;
        flush         = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        alloc_valid   = '0;
        release_valid = '0;
        stale_idx     = '0;
        flush         = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset view: a flush cycle shows lanes {32,33} without consuming them.
        step(2'b11, 2'b00, 0, 0, 1'b1);
        // Single lane 1 request compacts onto the head, then lane 0 gets the next.
        step(2'b10, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b00, 0, 0, 1'b0);

        // Drain to empty, then request while not ready.
        do_reset(1'b0);
        repeat (16) step(2'b11, 2'b00, 0, 0, 1'b0);
        repeat (2)  step(2'b11, 2'b00, 0, 0, 1'b0);

        // Same-cycle alloc and release at count 2, then wrap.
        do_reset(1'b0);
        repeat (15) step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b11, 0, 1, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b00, 0, 0, 1'b0);

        // Alloc 5, release two, flush, then walk the recovered list.
        do_reset(1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b11, 0, 1, 1'b0);
        step(2'b00, 2'b00, 0, 0, 1'b1);
        repeat (16) step(2'b11, 2'b00, 0, 0, 1'b0);

        // Release into a full list is dropped.
        do_reset(1'b0);
        step(2'b00, 2'b01, 5, 0, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);

        // Randomized traffic with occasional flushes and mid-run resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1'b1);
            end else begin
                step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                     ($urandom_range(0, 24) == 0));
            end
        end
        do_reset(1'b1);
        step(2'b11, 2'b00, 0, 0, 1'b0);

        @(negedge clk); #1;
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
